// File: rtl/bcd_seven_seg_scan.sv
// Double-buffered, blank-slotted 7-segment scanner for packed BCD values.
// Optional leading-zero suppression: define BCD_SCAN_LEADING_ZERO_BLANK_EN.
module bcd_seven_seg_scan #(
  parameter int DECIMAL_DIGITS = 3,
  parameter int REFRESH_CYCLES = 50000,
  parameter int BLANK_CYCLES   = 500
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_L,
  input  logic [DECIMAL_DIGITS*4-1:0]   i_BCD,
  input  logic                          i_DV,
  output logic [DECIMAL_DIGITS-1:0]     o_Anode,
  output logic [6:0]                    o_Segment,
  output logic                          o_Err,
  output logic                          o_Frame
);

  localparam int MAXC = (REFRESH_CYCLES > BLANK_CYCLES) ?
                        REFRESH_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int IW = (DECIMAL_DIGITS > 1) ?
                      $clog2(DECIMAL_DIGITS) : 1;
  localparam int BW = DECIMAL_DIGITS * 4;

  localparam logic [CW-1:0] R_LAST = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DECIMAL_DIGITS - 1);

  typedef enum logic {
    s_BLANK,
    s_DRIVE
  } state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [BW-1:0]             shadow_q, shadow_d;
  logic [BW-1:0]             active_q, active_d;
  logic [DECIMAL_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]                seg_q, seg_d;
  logic                      err_q, err_d;
  logic                      frame_q, frame_d;
  logic                      enter_drive;
  logic [3:0]                nib;
  logic                      lz;
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
  logic [IW-1:0]             msd;
`endif

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    active_d    = active_q;
    shadow_d    = i_DV ? i_BCD : shadow_q;
    anode_d     = anode_q;
    seg_d       = seg_q;
    err_d       = err_q;
    frame_d     = 1'b0;
    enter_drive = 1'b0;

    unique case (state_q)
      s_BLANK: begin
        if (cnt_q == B_LAST) begin
          state_d     = s_DRIVE;
          cnt_d       = '0;
          enter_drive = 1'b1;
          if (idx_q == I_LAST) begin
            idx_d    = '0;
            active_d = shadow_q;
            frame_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      s_DRIVE: begin
        if (cnt_q == R_LAST) begin
          state_d = s_BLANK;
          cnt_d   = '0;
          anode_d = '1;
          seg_d   = 7'h7F;
          err_d   = 1'b0;
        end
      end
      default: ;
    endcase

    // Decode from the post-edge index/active so anode and segments move together.
    nib = '0;
    for (int k = 0; k < DECIMAL_DIGITS; k++) begin
      if (idx_d == IW'(k)) nib = active_d[k*4 +: 4];
    end

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    msd = '0;
    for (int k = 0; k < DECIMAL_DIGITS; k++) begin
      if (active_d[k*4 +: 4] != 4'd0) msd = IW'(k);
    end
    lz = (idx_d > msd);
`else
    lz = 1'b0;
`endif

    if (enter_drive) begin
      for (int k = 0; k < DECIMAL_DIGITS; k++) begin
        anode_d[k] = (idx_d != IW'(k));
      end
      seg_d = lz ? 7'h7F : seg_of(nib);
      err_d = !lz && (nib > 4'd9);
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state_q  <= s_BLANK;
      cnt_q    <= '0;
      idx_q    <= I_LAST;
      shadow_q <= '0;
      active_q <= '0;
      anode_q  <= '1;
      seg_q    <= 7'h7F;
      err_q    <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
      err_q    <= err_d;
      frame_q  <= frame_d;
    end
  end

  assign o_Anode   = anode_q;
  assign o_Segment = seg_q;
  assign o_Err     = err_q;
  assign o_Frame   = frame_q;

endmodule

// File: tb/tb_bcd_seven_seg_scan.sv
// Bench for bcd_seven_seg_scan: frame-position model plus directed checks.
// Honors BCD_SCAN_LEADING_ZERO_BLANK_EN when defined.
module tb_bcd_seven_seg_scan;

  localparam int D = 3;
  localparam int R = 4;
  localparam int B = 1;
  localparam int P = D * (R + B);

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'b1000000;
`endif

  logic        clk = 1'b0;
  logic        rst_l;
  logic [11:0] bcd;
  logic        dv;
  logic [2:0]  anode;
  logic [6:0]  seg;
  logic        err;
  logic        frame;

  always #5 clk = ~clk;

  bcd_seven_seg_scan #(
    .DECIMAL_DIGITS(D),
    .REFRESH_CYCLES(R),
    .BLANK_CYCLES(B)
  ) dut (
    .i_Clock  (clk),
    .i_Rst_L  (rst_l),
    .i_BCD    (bcd),
    .i_DV     (dv),
    .o_Anode  (anode),
    .o_Segment(seg),
    .o_Err    (err),
    .o_Frame  (frame)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Model: position in frame derived from edges since reset release
  int          n = 0;
  bit          mvalid = 0;
  logic [11:0] m_shadow = '0;
  logic [11:0] m_active = '0;
  logic [2:0]  e_anode;
  logic [6:0]  e_seg;
  logic        e_err, e_frame;

  always @(posedge clk) begin
    int f, dig, ph, v, top;
    bit blank;
    if (!rst_l) begin
      n = 0;
      m_shadow = '0;
      m_active = '0;
      mvalid = 1;
    end else begin
      n++;
      if (n >= B && (n - B) % P == 0) m_active = m_shadow;
      if (dv) m_shadow = bcd;
    end
    e_anode = 3'b111;
    e_seg   = 7'h7F;
    e_err   = 1'b0;
    e_frame = 1'b0;
    if (rst_l && n >= B) begin
      f   = (n - B) % P;
      dig = f / (R + B);
      ph  = f % (R + B);
      if (ph < R) begin
        e_anode[dig] = 1'b0;
        v = int'(m_active[dig*4 +: 4]);
        top = 0;
        for (int k = 0; k < D; k++)
          if (m_active[k*4 +: 4] != 4'd0) top = k;
        blank = 0;
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
        blank = (dig > top);
`endif
        e_seg   = blank ? 7'h7F : seg_ref(v);
        e_err   = !blank && v > 9;
        e_frame = (f == 0);
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_anode", 32'(anode), 32'(e_anode));
      chk("model_seg",   32'(seg),   32'(e_seg));
      chk("model_err",   32'(err),   32'(e_err));
      chk("model_frame", 32'(frame), 32'(e_frame));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_frame(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (frame !== 1'b1 && cyc < 40);
    if (frame !== 1'b1) chk("frame_timeout", 32'(frame), 32'd1);
  endtask

  task automatic load(input logic [11:0] v);
    bcd = v;
    dv  = 1'b1;
    tick();
    dv  = 1'b0;
  endtask

  initial begin
    int c;
    rst_l = 1'b0;
    dv    = 1'b0;
    bcd   = '0;
    repeat (3) tick();
    chk("rst_anode", 32'(anode), 32'b111);
    chk("rst_seg",   32'(seg),   32'h7F);
    chk("rst_err",   32'(err),   32'd0);
    chk("rst_frame", 32'(frame), 32'd0);

    rst_l = 1'b1;
    tick();
    chk("first_frame", 32'(frame), 32'd1);
    chk("first_anode", 32'(anode), 32'b110);
    chk("first_seg",   32'(seg),   32'b1000000);
    repeat (3) tick();
    chk("first_hold",  32'(anode), 32'b110);
    tick();
    chk("first_blank", 32'(anode), 32'b111);

    load(12'h123);
    wait_frame(c);
    wait_frame(c);
    chk("period", 32'(c), 32'd15);
    chk("cap_d0", 32'(seg), 32'b0110000);
    chk("cap_a0", 32'(anode), 32'b110);
    repeat (5) tick();
    chk("cap_d1", 32'(seg), 32'b0100100);
    chk("cap_a1", 32'(anode), 32'b101);
    repeat (5) tick();
    chk("cap_d2", 32'(seg), 32'b1111001);
    chk("cap_a2", 32'(anode), 32'b011);

    repeat (4) tick();
    load(12'h456);
    chk("col_frame", 32'(frame), 32'd1);
    chk("col_old",   32'(seg),   32'b0110000);
    wait_frame(c);
    chk("col_period", 32'(c), 32'd15);
    chk("col_d0", 32'(seg), 32'b0000010);
    repeat (5) tick();
    chk("col_d1", 32'(seg), 32'b0010010);
    repeat (5) tick();
    chk("col_d2", 32'(seg), 32'b0011001);

    load(12'hA09);
    wait_frame(c);
    wait_frame(c);
    chk("err_d0", 32'(seg), 32'b0010000);
    chk("err_e0", 32'(err), 32'd0);
    repeat (5) tick();
    chk("err_d1", 32'(seg), 32'b1000000);
    repeat (5) tick();
    chk("err_d2", 32'(seg), 32'b0111111);
    chk("err_e2", 32'(err), 32'd1);
    repeat (3) tick();
    chk("err_e2_last", 32'(err), 32'd1);
    tick();
    chk("err_e2_off", 32'(err), 32'd0);

    load(12'h007);
    wait_frame(c);
    wait_frame(c);
    chk("lz_d0", 32'(seg), 32'b1111000);
    repeat (5) tick();
    chk("lz_d1", 32'(seg), 32'(LZ_SEG));
    chk("lz_a1", 32'(anode), 32'b101);
    repeat (5) tick();
    chk("lz_d2", 32'(seg), 32'(LZ_SEG));

    wait_frame(c);
    repeat (5) tick();
    load(12'h999);
    rst_l = 1'b0;
    tick();
    chk("mid_rst_anode", 32'(anode), 32'b111);
    chk("mid_rst_seg",   32'(seg),   32'h7F);
    tick();
    rst_l = 1'b1;
    tick();
    chk("post_rst_frame", 32'(frame), 32'd1);
    chk("post_rst_d0",    32'(seg),   32'b1000000);
    repeat (5) tick();
    chk("post_rst_d1",    32'(seg),   32'(LZ_SEG));
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
